quad_step_decoder: RTL and testbench



---
 rtl/quad_step_decoder.sv | 221 ++++++++++++++++++++++
 tb/tb_quad_step_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// ---------------------------------------------------------------------------
// quad_step_decoder
// Turns a raw asynchronous quadrature pair (qa/qb) into one-cycle inc/dec
// step pulses for the downstream up/down counter. The input pair is
// synchronized and glitch filtered, then the quadrature position is tracked.
// Partial edges are accumulated until a full step is reached. A transition
// where both bits change is flagged as illegal.
//
// Ports:
//   clk      in   clock, all state on the rising edge
//   rst      in   asynchronous active-high reset
//   qa, qb   in   raw quadrature phases (asynchronous)
//   en       in   0: keep tracking position but suppress inc/dec
//   clr_err  in   synchronous clear of err_cnt (wins over an increment)
//   inc      out  one-cycle pulse, one forward step
//   dec      out  one-cycle pulse, one reverse step
//   err      out  one-cycle pulse on an illegal double-bit transition
//   err_cnt  out  saturating count of illegal transitions
// ---------------------------------------------------------------------------
module quad_step_decoder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILT_LEN       = 4,
    parameter int unsigned EDGES_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       qa,
    input  logic       qb,
    input  logic       en,
    input  logic       clr_err,
    output logic       inc,
    output logic       dec,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] FILT_MAX  = CNT_W'(FILT_LEN);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_LEN - 1);
    // Step thresholds as 4-bit two's complement patterns (+E and -E).
    localparam logic signed [3:0] EPS_POS = 4'(EDGES_PER_STEP);
    localparam logic signed [3:0] EPS_NEG = 4'(16 - EDGES_PER_STEP);

    // Elaboration-time parameter range checks.
    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("quad_step_decoder: SYNC_STAGES must be 2..4");
        end
        if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt
            $error("quad_step_decoder: FILT_LEN must be 1..15");
        end
        if (EDGES_PER_STEP != 1 && EDGES_PER_STEP != 2 && EDGES_PER_STEP != 4) begin : g_bad_eps
            $error("quad_step_decoder: EDGES_PER_STEP must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             sab;
    logic [1:0]             sab_q;
    logic                   sab_same;
    logic [CNT_W-1:0]       stab_cnt;
    logic                   fab_load;
    logic [1:0]             fab;
    logic                   fab_upd;

    state_t                 state;
    state_t                 state_nxt;
    logic [1:0]             ref_ab;
    logic [1:0]             ref_d;
    logic [1:0]             pos_delta;
    logic signed [2:0]      acc;
    logic signed [2:0]      acc_d;
    logic signed [3:0]      acc_sum;
    logic                   inc_d;
    logic                   dec_d;
    logic                   err_d;
    logic [7:0]             err_cnt_d;

    // Gray-code position of a quadrature value; forward order 00,01,11,10.
    function automatic logic [1:0] gray_pos(input logic [1:0] v);
        case (v)
            2'b00:   gray_pos = 2'd0;
            2'b01:   gray_pos = 2'd1;
            2'b11:   gray_pos = 2'd2;
            default: gray_pos = 2'd3;
        endcase
    endfunction

    // Synchronizer chains for the asynchronous phase inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], qa};
            sync_b <= {sync_b[SYNC_STAGES-2:0], qb};
        end
    end

    assign sab      = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    assign sab_same = (sab == sab_q);
    // Accept the value once it has survived the full stability window.
    assign fab_load = sab_same && (stab_cnt == FILT_LAST);

    // Glitch filter: stability counter and accepted value fab.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sab_q    <= '0;
            stab_cnt <= '0;
            fab      <= '0;
            fab_upd  <= 1'b0;
        end else begin
            sab_q <= sab;
            if (!sab_same) begin
                stab_cnt <= '0;
            end else if (stab_cnt != FILT_MAX) begin
                stab_cnt <= stab_cnt + CNT_W'(1);
            end
            if (fab_load) begin
                fab <= sab;
            end
            fab_upd <= fab_load;
        end
    end

    // Movement relative to the reference, modulo 4 (2 means both bits flipped).
    assign pos_delta = gray_pos(fab) - gray_pos(ref_ab);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: leave INIT on the first accepted value.
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && fab_upd) begin
            state_nxt = ST_TRACK;
        end
    end

    // FSM outputs: accumulator, step pulses and error bookkeeping.
    always_comb begin
        acc_d     = acc;
        ref_d     = ref_ab;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt;
        acc_sum   = {acc[2], acc};

        if (fab_upd) begin
            ref_d = fab;
            if (state == ST_TRACK) begin
                case (pos_delta)
                    2'd1: acc_sum = acc_sum + 4'sd1;
                    2'd3: acc_sum = acc_sum - 4'sd1;
                    2'd2: begin
                        err_d   = 1'b1;
                        acc_sum = '0;
                        if (err_cnt != 8'hFF) begin
                            err_cnt_d = err_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (acc_sum == EPS_POS) begin
            inc_d = 1'b1;
            acc_d = '0;
        end else if (acc_sum == EPS_NEG) begin
            dec_d = 1'b1;
            acc_d = '0;
        end else begin
            acc_d = acc_sum[2:0];
        end

        // Disabled: keep the accumulator empty so re-enabling starts clean.
        if (!en) begin
            acc_d = '0;
            inc_d = 1'b0;
            dec_d = 1'b0;
        end

        if (clr_err) begin
            err_cnt_d = '0;
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_ab  <= '0;
            acc     <= '0;
            inc     <= 1'b0;
            dec     <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            ref_ab  <= ref_d;
            acc     <= acc_d;
            inc     <= inc_d;
            dec     <= dec_d;
            err     <= err_d;
            err_cnt <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_step_decoder
// Directed bench for quad_step_decoder. Expected pulses (kind + cycle) are
// queued when a phase change is driven and matched when the DUT pulses.
// A second instance with EDGES_PER_STEP=1 covers the one-edge-per-step case.
// ---------------------------------------------------------------------------
module tb_quad_step_decoder;

    localparam int HOLD     = 10;
    localparam int LAT      = 8;   // drive negedge -> observe negedge
    localparam int FILT_LEN = 4;
    localparam int K_NONE   = 0;
    localparam int K_INC    = 1;
    localparam int K_DEC    = 2;
    localparam int K_ERR    = 3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       qa, qb, en, clr_err;
    logic       inc, dec, err;
    logic [7:0] err_cnt;
    logic       qa1, qb1;
    logic       inc1, dec1, err1;
    logic [7:0] err_cnt1;

    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    int  last_inc1 = -1000;
    int  exp_errcnt;
    ev_t q0[$];
    ev_t q1[$];

    quad_step_decoder u_dut (
        .clk(clk), .rst(rst), .qa(qa), .qb(qb), .en(en), .clr_err(clr_err),
        .inc(inc), .dec(dec), .err(err), .err_cnt(err_cnt)
    );

    quad_step_decoder #(.EDGES_PER_STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .qa(qa1), .qb(qb1), .en(en), .clr_err(clr_err),
        .inc(inc1), .dec(dec1), .err(err1), .err_cnt(err_cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the default instance.
    always @(negedge clk) begin
        ev_t obs, expv;
        if (!rst && (inc || dec || err)) begin
            obs.kind = inc ? 2'(K_INC) : (dec ? 2'(K_DEC) : 2'(K_ERR));
            obs.cyc  = 32'(cyc);
            vectors++;
            assert (!(inc && dec)) else begin
                miscompares++;
                $error("FAIL excl0: inc=%0b dec=%0b at cycle %0d, required not both", inc, dec, cyc);
            end
            vectors++;
            if (q0.size() == 0) begin
                miscompares++;
                $error("FAIL unexp0: kind=%0d cycle=%0d, required no pulse", obs.kind, obs.cyc);
            end else begin
                expv = q0.pop_front();
                assert (obs === expv) else begin
                    miscompares++;
                    $error("FAIL pulse0: kind=%0d cycle=%0d, required kind=%0d cycle=%0d",
                           obs.kind, obs.cyc, expv.kind, expv.cyc);
                end
            end
        end
    end

    // Scoreboard for the one-edge-per-step instance.
    always @(negedge clk) begin
        ev_t obs, expv;
        if (!rst && (inc1 || dec1 || err1)) begin
            obs.kind = inc1 ? 2'(K_INC) : (dec1 ? 2'(K_DEC) : 2'(K_ERR));
            obs.cyc  = 32'(cyc);
            if (inc1) begin
                vectors++;
                assert (cyc - last_inc1 >= FILT_LEN) else begin
                    miscompares++;
                    $error("FAIL spacing1: gap=%0d, required >= %0d", cyc - last_inc1, FILT_LEN);
                end
                last_inc1 = cyc;
            end
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $error("FAIL unexp1: kind=%0d cycle=%0d, required no pulse", obs.kind, obs.cyc);
            end else begin
                expv = q1.pop_front();
                assert (obs === expv) else begin
                    miscompares++;
                    $error("FAIL pulse1: kind=%0d cycle=%0d, required kind=%0d cycle=%0d",
                           obs.kind, obs.cyc, expv.kind, expv.cyc);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, expv);
        end
    endtask

    // Drive one phase value on the chosen instance, queue its pulse, then hold.
    task automatic step(input int which, input logic a, input logic b, input int kind);
        ev_t e;
        if (which == 0) begin
            qa = a;
            qb = b;
        end else begin
            qa1 = a;
            qb1 = b;
        end
        if (kind != K_NONE) begin
            e.kind = 2'(kind);
            e.cyc  = 32'(cyc + LAT);
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
        repeat (HOLD) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; qa = 1'b0; qb = 1'b0; qa1 = 1'b0; qb1 = 1'b0;
        en = 1'b1; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_inc", 32'(inc), 0);
        chk("rst_dec", 32'(dec), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_errcnt", 32'(err_cnt), 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // Four forward edges -> one inc on the fourth.
        step(0, 1'b0, 1'b1, K_NONE);
        step(0, 1'b1, 1'b1, K_NONE);
        step(0, 1'b1, 1'b0, K_NONE);
        step(0, 1'b0, 1'b0, K_INC);

        // Four reverse edges -> one dec.
        step(0, 1'b1, 1'b0, K_NONE);
        step(0, 1'b1, 1'b1, K_NONE);
        step(0, 1'b0, 1'b1, K_NONE);
        step(0, 1'b0, 1'b0, K_DEC);

        // Forward one, back one: no pulse; then a full forward step.
        step(0, 1'b0, 1'b1, K_NONE);
        step(0, 1'b0, 1'b0, K_NONE);
        step(0, 1'b0, 1'b1, K_NONE);
        step(0, 1'b1, 1'b1, K_NONE);
        step(0, 1'b1, 1'b0, K_NONE);
        step(0, 1'b0, 1'b0, K_INC);

        // Two-cycle glitch on qa is filtered out.
        qa = 1'b1;
        repeat (2) @(negedge clk);
        qa = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_errcnt", 32'(err_cnt), 0);

        // Illegal double-bit transitions, count saturates at 255.
        exp_errcnt = 0;
        for (int i = 0; i < 300; i++) begin
            step(0, (i % 2 == 0), (i % 2 == 0), K_ERR);
            if (exp_errcnt < 255) exp_errcnt++;
            chk("errcnt", 32'(err_cnt), 32'(exp_errcnt));
        end

        // clr_err in the same cycle as an error: err still pulses, count clears.
        begin
            ev_t e;
            qa = 1'b1; qb = 1'b1;
            e.kind = 2'(K_ERR);
            e.cyc  = 32'(cyc + LAT);
            q0.push_back(e);
            repeat (LAT - 1) @(negedge clk);
            clr_err = 1'b1;
            @(negedge clk);
            clr_err = 1'b0;
            chk("clr_wins", 32'(err_cnt), 0);
            repeat (4) @(negedge clk);
            chk("clr_hold", 32'(err_cnt), 0);
        end

        // Reset mid-step with qa=qb=1: partial edges lost, INIT adopts 11.
        step(0, 1'b1, 1'b0, K_NONE);
        step(0, 1'b0, 1'b0, K_NONE);
        rst = 1'b1; qa = 1'b1; qb = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst2_inc", 32'(inc), 0);
        chk("rst2_errcnt", 32'(err_cnt), 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("init11_errcnt", 32'(err_cnt), 0);
        step(0, 1'b1, 1'b0, K_NONE);
        step(0, 1'b0, 1'b0, K_NONE);
        step(0, 1'b0, 1'b1, K_NONE);
        step(0, 1'b1, 1'b1, K_INC);

        // en=0 over eight forward edges, then enabled for one full step.
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(0, 1'b1, 1'b0, K_NONE);
            step(0, 1'b0, 1'b0, K_NONE);
            step(0, 1'b0, 1'b1, K_NONE);
            step(0, 1'b1, 1'b1, K_NONE);
        end
        en = 1'b1;
        repeat (2) @(negedge clk);
        step(0, 1'b1, 1'b0, K_NONE);
        step(0, 1'b0, 1'b0, K_NONE);
        step(0, 1'b0, 1'b1, K_NONE);
        step(0, 1'b1, 1'b1, K_INC);

        // One edge per step: every forward edge is an inc.
        step(1, 1'b0, 1'b1, K_INC);
        step(1, 1'b1, 1'b1, K_INC);
        step(1, 1'b1, 1'b0, K_INC);
        step(1, 1'b0, 1'b0, K_INC);

        repeat (20) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        chk("errcnt1", 32'(err_cnt1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
